// File: rtl/cascade_pkg.sv
// rtl/cascade_pkg.sv - shared types for the cascade window-position path
package cascade_pkg;

  // Default image geometry used to size the shared position types.
  localparam int DEF_IMG_WIDTH  = 45;
  localparam int DEF_IMG_HEIGHT = 45;
  localparam int POS_W_X        = $clog2(DEF_IMG_WIDTH);
  localparam int POS_W_Y        = $clog2(DEF_IMG_HEIGHT);

  typedef logic [POS_W_X-1:0] pos_x_t;
  typedef logic [POS_W_Y-1:0] pos_y_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - strided position counter that wraps to 0 past MAX
module step_counter #(
  parameter int MAX  = 21,
  parameter int STEP = 1,
  parameter int W    = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  // Compare one bit wider than the value so value+STEP cannot wrap first.
  localparam logic [W:0] STEP_W = (W+1)'(STEP);
  localparam logic [W:0] MAX_W  = (W+1)'(MAX);

  logic [W:0] next_value;

  // wrap flags that the current value is the final position of the row/column.
  always_comb begin
    next_value = {1'b0, value} + STEP_W;
    wrap       = (next_value > MAX_W);
  end

  // Advance by STEP on inc, returning to 0 after the final position.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : next_value[W-1:0];
    end
  end

endmodule

// File: rtl/window_scanner.sv
// rtl/window_scanner.sv - raster window-origin generator; option WINDOW_SCANNER_LAST_EN adds window_pos_last
module window_scanner
  import cascade_pkg::*;
#(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int WIN_WIDTH  = 24,
  parameter int WIN_HEIGHT = 24,
  parameter int STEP_X     = 1,
  parameter int STEP_Y     = 1,
  localparam int W_X       = $clog2(IMG_WIDTH),
  localparam int W_Y       = $clog2(IMG_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           window_pos_valid,
  input  logic           window_pos_ready,
  output logic [W_X-1:0] window_pos_x,
  output logic [W_Y-1:0] window_pos_y
`ifdef WINDOW_SCANNER_LAST_EN
  ,
  output logic           window_pos_last
`endif
);

  localparam int MAX_X = IMG_WIDTH - WIN_WIDTH;
  localparam int MAX_Y = IMG_HEIGHT - WIN_HEIGHT;

  if (MAX_X < 0) begin : g_bad_width
    $error("window_scanner: WIN_WIDTH exceeds IMG_WIDTH");
  end
  if (MAX_Y < 0) begin : g_bad_height
    $error("window_scanner: WIN_HEIGHT exceeds IMG_HEIGHT");
  end
  if (STEP_X == 0 || STEP_Y == 0) begin : g_bad_step
    $error("window_scanner: STEP_X and STEP_Y must be non-zero");
  end

  scan_state_t state, state_next;
  logic        handshake;
  logic        x_wrap, y_wrap;
  logic        cnt_clr;

  assign handshake = window_pos_valid & window_pos_ready;
  assign cnt_clr   = (state != SCAN);

  step_counter #(.MAX(MAX_X), .STEP(STEP_X), .W(W_X)) u_x_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (handshake),
    .value (window_pos_x),
    .wrap  (x_wrap)
  );

  step_counter #(.MAX(MAX_Y), .STEP(STEP_Y), .W(W_Y)) u_y_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (handshake & x_wrap),
    .value (window_pos_y),
    .wrap  (y_wrap)
  );

  // State register; reset aborts any scan without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_next       = state;
    busy             = 1'b0;
    done             = 1'b0;
    window_pos_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = SCAN;
      end
      SCAN: begin
        busy             = 1'b1;
        window_pos_valid = 1'b1;
        if (handshake && x_wrap && y_wrap) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef WINDOW_SCANNER_LAST_EN
  // Final origin is the one where both counters sit on their last position.
  always_comb begin
    window_pos_last = (state == SCAN) && x_wrap && y_wrap;
  end
`endif

endmodule

// File: tb/tb_window_scanner.sv
// tb/tb_window_scanner.sv - directed self-checking bench for window_scanner
module tb_window_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // dut0: defaults (22x22 origins)
  logic       start0 = 0, ready0 = 0;
  logic       busy0, done0, valid0;
  logic [5:0] x0, y0;
  // dut1: STEP_X=4, STEP_Y=7
  logic       start1 = 0, ready1 = 0;
  logic       busy1, done1, valid1;
  logic [5:0] x1, y1;
  // dut2: degenerate 24x24 image
  logic       start2 = 0, ready2 = 0;
  logic       busy2, done2, valid2;
  logic [4:0] x2, y2;
`ifdef WINDOW_SCANNER_LAST_EN
  logic       last0, last1, last2;
`endif

  window_scanner dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .window_pos_valid(valid0), .window_pos_ready(ready0),
    .window_pos_x(x0), .window_pos_y(y0)
`ifdef WINDOW_SCANNER_LAST_EN
    , .window_pos_last(last0)
`endif
  );

  window_scanner #(.STEP_X(4), .STEP_Y(7)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .window_pos_valid(valid1), .window_pos_ready(ready1),
    .window_pos_x(x1), .window_pos_y(y1)
`ifdef WINDOW_SCANNER_LAST_EN
    , .window_pos_last(last1)
`endif
  );

  window_scanner #(.IMG_WIDTH(24), .IMG_HEIGHT(24)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .window_pos_valid(valid2), .window_pos_ready(ready2),
    .window_pos_x(x2), .window_pos_y(y2)
`ifdef WINDOW_SCANNER_LAST_EN
    , .window_pos_last(last2)
`endif
  );

  // Runs one scan on dut0 from a negedge. Model: x 0..21 inner, y 0..21 outer.
  task automatic scan0(input bit rnd, input int pulse_at, input int abort_at,
                       output int hs, output int ndone);
    int ex, ey, cyc;
    bit held;
    logic [5:0] hx, hy;
    ex = 0; ey = 0; hs = 0; ndone = 0; held = 0; hx = 0; hy = 0;
    start0 = 1;
    for (cyc = 1; cyc <= 5000; cyc++) begin
      @(negedge clk);
      start0 = 0;
      if (cyc == 1) begin
        checks++;
        if (valid0 !== 1'b1 || x0 !== 6'd0 || y0 !== 6'd0) begin
          errors++;
          $display("FAIL first_origin valid=%0b x=%0d y=%0d required valid=1 x=0 y=0", valid0, x0, y0);
        end
      end
      if (held) begin
        checks++;
        if (valid0 !== 1'b1 || x0 !== hx || y0 !== hy) begin
          errors++;
          $display("FAIL hold_stable valid=%0b x=%0d y=%0d required valid=1 x=%0d y=%0d", valid0, x0, y0, hx, hy);
        end
      end
      held = 0;
      if (done0 === 1'b1) begin
        ndone++;
        checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0 || hs != 484) begin
          errors++;
          $display("FAIL done_state valid=%0b busy=%0b handshakes=%0d required 0 0 484", valid0, busy0, hs);
        end
        ready0 = 0;
        break;
      end
      checks++;
      if (valid0 !== 1'b1 || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL scan_flags valid=%0b busy=%0b required 1 1 at origin %0d", valid0, busy0, hs);
        ready0 = 0;
        break;
      end
      if (hs == abort_at) begin
        rst = 1; ready0 = 0;
        break;
      end
      if (hs == pulse_at) start0 = 1;
      ready0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready0) begin
        checks++;
        if (x0 !== 6'(ex) || y0 !== 6'(ey)) begin
          errors++;
          $display("FAIL origin_%0d x=%0d y=%0d required x=%0d y=%0d", hs, x0, y0, ex, ey);
        end
        hs++;
        ex++;
        if (ex > 21) begin ex = 0; ey++; end
      end else begin
        held = 1; hx = x0; hy = y0;
      end
    end
    if (cyc > 5000) begin
      errors++;
      $display("FAIL scan_timeout handshakes=%0d required 484", hs);
      ready0 = 0;
    end
  endtask

  task automatic check_idle0(input string name);
    checks++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL %s valid=%0b busy=%0b done=%0b required 0 0 0", name, valid0, busy0, done0);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid0 !== 0 || x0 !== 0 || y0 !== 0 || busy0 !== 0 || done0 !== 0 ||
        valid1 !== 0 || busy1 !== 0 || valid2 !== 0 || done2 !== 0) begin
      errors++;
      $display("FAIL reset_values valid=%0b x=%0d y=%0d busy=%0b done=%0b required all 0", valid0, x0, y0, busy0, done0);
    end
    rst = 0;
    @(negedge clk);
    check_idle0("idle_after_reset");
  endtask

  task automatic test_full_scan;
    int hs, nd;
    scan0(0, -1, -1, hs, nd);
    checks++;
    if (hs != 484 || nd != 1) begin
      errors++;
      $display("FAIL full_scan handshakes=%0d dones=%0d required 484 1", hs, nd);
    end
    @(negedge clk);
    check_idle0("done_single_pulse");
  endtask

  task automatic test_backpressure;
    int hs, nd;
    scan0(1, -1, -1, hs, nd);
    checks++;
    if (hs != 484 || nd != 1) begin
      errors++;
      $display("FAIL backpressure handshakes=%0d dones=%0d required 484 1", hs, nd);
    end
    @(negedge clk);
    check_idle0("backpressure_idle");
  endtask

  task automatic test_start_while_busy;
    int hs, nd;
    scan0(0, 3 * 22 + 5, -1, hs, nd);
    checks++;
    if (hs != 484 || nd != 1) begin
      errors++;
      $display("FAIL start_busy handshakes=%0d dones=%0d required 484 1", hs, nd);
    end
    repeat (3) begin
      @(negedge clk);
      check_idle0("start_busy_no_restart");
    end
  endtask

  task automatic test_reset_mid_scan;
    int hs, nd;
    scan0(0, -1, 10 * 22 + 10, hs, nd);
    checks++;
    if (hs != 230 || x0 !== 6'd10 || y0 !== 6'd10) begin
      errors++;
      $display("FAIL abort_point handshakes=%0d x=%0d y=%0d required 230 10 10", hs, x0, y0);
    end
    @(negedge clk);
    checks++;
    if (valid0 !== 0 || x0 !== 0 || y0 !== 0 || busy0 !== 0 || done0 !== 0) begin
      errors++;
      $display("FAIL abort_state valid=%0b x=%0d y=%0d busy=%0b done=%0b required all 0", valid0, x0, y0, busy0, done0);
    end
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      check_idle0("abort_no_done");
    end
    scan0(0, -1, -1, hs, nd);
    checks++;
    if (hs != 484 || nd != 1) begin
      errors++;
      $display("FAIL restart handshakes=%0d dones=%0d required 484 1", hs, nd);
    end
    @(negedge clk);
  endtask

  task automatic test_steps;
    int ex, ey, hs, cyc;
    bit fin;
    ex = 0; ey = 0; hs = 0; fin = 0;
    start1 = 1; ready1 = 1;
    for (cyc = 0; cyc < 100 && !fin; cyc++) begin
      @(negedge clk);
      start1 = 0;
      if (done1 === 1'b1) begin
        fin = 1;
      end else if (valid1 === 1'b1) begin
        checks++;
        if (x1 !== 6'(ex) || y1 !== 6'(ey)) begin
          errors++;
          $display("FAIL step_origin_%0d x=%0d y=%0d required x=%0d y=%0d", hs, x1, y1, ex, ey);
        end
        hs++;
        if (ex + 4 <= 21) ex += 4;
        else begin ex = 0; ey += 7; end
      end
    end
    checks++;
    if (!fin || hs != 24 || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL step_count handshakes=%0d done_seen=%0b required 24 1", hs, fin);
    end
    ready1 = 0;
    @(negedge clk);
  endtask

  task automatic test_degenerate_back_to_back;
    for (int run = 0; run < 2; run++) begin
      start2 = 1; ready2 = 1;
      @(negedge clk);
      if (run == 0) start2 = 0;
      checks++;
      if (valid2 !== 1'b1 || x2 !== 5'd0 || y2 !== 5'd0 || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL degen_origin run=%0d valid=%0b x=%0d y=%0d required 1 0 0", run, valid2, x2, y2);
      end
`ifdef WINDOW_SCANNER_LAST_EN
      checks++;
      if (last2 !== 1'b1) begin
        errors++;
        $display("FAIL degen_last last=%0b required 1", last2);
      end
`endif
      @(negedge clk);
      checks++;
      if (done2 !== 1'b1 || valid2 !== 1'b0) begin
        errors++;
        $display("FAIL degen_done done=%0b valid=%0b required 1 0", done2, valid2);
      end
`ifdef WINDOW_SCANNER_LAST_EN
      checks++;
      if (last2 !== 1'b0) begin
        errors++;
        $display("FAIL degen_last_low last=%0b required 0", last2);
      end
`endif
      // start held through DONE is ignored there and only taken in IDLE
      start2 = 1;
      @(negedge clk);
      checks++;
      if (valid2 !== 1'b0 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL degen_idle valid=%0b done=%0b required 0 0", valid2, done2);
      end
      if (run == 1) start2 = 0;
    end
    @(negedge clk);
    ready2 = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_full_scan;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid_scan;
    test_steps;
    test_degenerate_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
